// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, destination field position, link mapping
// and credit defaults for the group egress arbiter.
package noc_pkg;

    localparam int DATA_W     = 16;
    localparam int GRP_W      = 3;
    localparam int NUM_GROUPS = 8;
    localparam int NUM_LINKS  = NUM_GROUPS - 1;

    localparam int DEST_MSB = DATA_W - 1;
    localparam int DEST_LSB = DATA_W - GRP_W;

    localparam int DEF_CREDITS = 4;
    localparam int DEF_CNT_W   = 3;

    typedef enum logic {
        LINK_ACTIVE  = 1'b0,
        LINK_STALLED = 1'b1
    } link_state_e;

    // Each group has no link to itself, so destinations above our id shift down by one.
    function automatic logic [GRP_W-1:0] dest_to_link(input logic [GRP_W-1:0] dest,
                                                      input logic [GRP_W-1:0] group_id);
        return (dest < group_id) ? dest : dest - 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the requester after the last winner;
// the pointer moves only when en_i is high.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d, sel;
    logic             found;
    int               idx;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = PTR_W'(idx);
            if (!found && req_i[sel]) begin
                found      = 1'b1;
                gnt_o[sel] = 1'b1;
                ptr_d      = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/group_egress_arbiter.sv
// Shares a group's 7 credit-flow-controlled global links among NUM_REQ local requesters.
// Optional ARB_STATS_EN adds per-link stall counters on stat_stall.
module group_egress_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = noc_pkg::DATA_W,
    parameter int GROUP_ID = 0,
    parameter int CREDITS  = DEF_CREDITS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_LINKS*DATA_W-1:0] link_data,
    output logic [NUM_LINKS-1:0]        link_valid,
    input  logic [NUM_LINKS-1:0]        link_credit,
`ifdef ARB_STATS_EN
    output logic [NUM_LINKS*16-1:0]     stat_stall,
`endif
    output logic                        err_self,
    output logic                        err_credit
);

    logic [NUM_REQ-1:0]                   self_req;
    logic [GRP_W-1:0]                     req_link [NUM_REQ];
    logic [NUM_LINKS-1:0][NUM_REQ-1:0]    gnt_all;
    logic [NUM_LINKS-1:0]                 credit_ovf;
    logic                                 err_self_q, err_credit_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [GRP_W-1:0] dest;
            assign dest          = req_data[gi*DATA_W + DEST_LSB +: GRP_W];
            assign self_req[gi]  = req_valid[gi] && (dest == GRP_W'(GROUP_ID));
            assign req_link[gi]  = dest_to_link(dest, GRP_W'(GROUP_ID));
        end

        for (gi = 0; gi < NUM_LINKS; gi++) begin : g_link
            logic [NUM_REQ-1:0] cand, arb_req, gnt;
            logic [CNT_W-1:0]   credit_q, credit_d;
            logic               valid_q, ovf;
            logic [DATA_W-1:0]  data_q, win_data;
            link_state_e        state;

            always_comb begin
                cand = '0;
                for (int r = 0; r < NUM_REQ; r++) begin
                    cand[r] = req_valid[r] && !self_req[r] && (req_link[r] == GRP_W'(gi));
                end
            end

            assign state   = (credit_q == '0) ? LINK_STALLED : LINK_ACTIVE;
            assign arb_req = (state == LINK_ACTIVE) ? cand : '0;

            rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
                .ACLK   (ACLK),
                .ARESET (ARESET),
                .req_i  (arb_req),
                .en_i   (|gnt),
                .gnt_o  (gnt)
            );

            always_comb begin
                win_data = '0;
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (gnt[r]) win_data = win_data | req_data[r*DATA_W +: DATA_W];
                end
            end

            // A grant and a returned credit in the same cycle cancel out.
            always_comb begin
                credit_d = credit_q;
                ovf      = 1'b0;
                if ((|gnt) && !link_credit[gi]) begin
                    credit_d = credit_q - 1'b1;
                end else if (!(|gnt) && link_credit[gi]) begin
                    if (credit_q == CNT_W'(CREDITS)) ovf = 1'b1;
                    else                             credit_d = credit_q + 1'b1;
                end
            end

            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) begin
                    credit_q <= CNT_W'(CREDITS);
                    valid_q  <= 1'b0;
                    data_q   <= '0;
                end else begin
                    credit_q <= credit_d;
                    valid_q  <= |gnt;
                    if (|gnt) data_q <= win_data;
                end
            end

            assign gnt_all[gi]                     = gnt;
            assign credit_ovf[gi]                  = ovf;
            assign link_valid[gi]                  = valid_q;
            assign link_data[gi*DATA_W +: DATA_W]  = data_q;

`ifdef ARB_STATS_EN
            logic [15:0] stall_q;
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) begin
                    stall_q <= '0;
                end else if ((state == LINK_STALLED) && (|cand) && (stall_q != 16'hFFFF)) begin
                    stall_q <= stall_q + 1'b1;
                end
            end
            assign stat_stall[gi*16 +: 16] = stall_q;
`endif
        end
    endgenerate

    // Self-addressed flits are acknowledged immediately and discarded.
    always_comb begin
        req_ready = self_req;
        for (int l = 0; l < NUM_LINKS; l++) begin
            req_ready = req_ready | gnt_all[l];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            err_self_q   <= 1'b0;
            err_credit_q <= 1'b0;
        end else begin
            err_self_q   <= err_self_q | (|self_req);
            err_credit_q <= err_credit_q | (|credit_ovf);
        end
    end

    assign err_self   = err_self_q;
    assign err_credit = err_credit_q;

endmodule

// File: tb/tb_group_egress_arbiter.sv
// Self-checking bench for group_egress_arbiter (GROUP_ID=2): directed table, reset
// sequence, and randomized traffic against a queue-level reference model.
module tb_group_egress_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 16;
    localparam int NL  = 7;
    localparam int GID = 2;
    localparam int CR  = 4;

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic [NL*DW-1:0] link_data;
    logic [NL-1:0]    link_valid;
    logic [NL-1:0]    link_credit;
    logic             err_self, err_credit;

    always #5 ACLK = ~ACLK;

    group_egress_arbiter #(
        .NUM_REQ(NR), .DATA_W(DW), .GROUP_ID(GID), .CREDITS(CR), .CNT_W(3)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .link_data   (link_data),
        .link_valid  (link_valid),
        .link_credit (link_credit),
        .err_self    (err_self),
        .err_credit  (err_credit)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int lk(input int d);
        return (d < GID) ? d : d - 1;
    endfunction

    typedef struct {
        logic [3:0]  rv;
        logic [63:0] d;
        logic [6:0]  lc;
        logic [3:0]  rdy;
        logic [6:0]  lv;
        int          cl;
        logic [15:0] ld;
        logic        es;
        logic        ec;
    } vec_t;

    vec_t tbl [18];

    // Reference model state for the random phase
    int          mcred  [NL];
    int          mstart [NL];
    int          win    [NL];
    bit          pv     [NR];
    logic [15:0] pd     [NR];
    bit          mes, mec;
    logic [3:0]  exp_rdy;
    logic [6:0]  exp_lv;
    int          cnt;

    task automatic do_reset();
        ARESET      = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        link_credit = '0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'h1, {16'h0, 16'h0, 16'h0, 16'h8ABC},       7'h00, 4'h1, 7'h08, 3, 16'h8ABC, 1'b0, 1'b0};
        tbl[1]  = '{4'hF, {16'hA013, 16'hA012, 16'hA011, 16'hA010}, 7'h00, 4'h1, 7'h10, 4, 16'hA010, 1'b0, 1'b0};
        tbl[2]  = '{4'hF, {16'hA013, 16'hA012, 16'hA011, 16'hA020}, 7'h00, 4'h2, 7'h10, 4, 16'hA011, 1'b0, 1'b0};
        tbl[3]  = '{4'hF, {16'hA013, 16'hA012, 16'hA011, 16'hA020}, 7'h00, 4'h4, 7'h10, 4, 16'hA012, 1'b0, 1'b0};
        tbl[4]  = '{4'hF, {16'hA013, 16'hA012, 16'hA011, 16'hA020}, 7'h00, 4'h8, 7'h10, 4, 16'hA013, 1'b0, 1'b0};
        tbl[5]  = '{4'h1, {16'h0, 16'h0, 16'h0, 16'hA020},       7'h00, 4'h0, 7'h00, -1, 16'h0, 1'b0, 1'b0};
        tbl[6]  = '{4'h1, {16'h0, 16'h0, 16'h0, 16'hA020},       7'h10, 4'h0, 7'h00, -1, 16'h0, 1'b0, 1'b0};
        tbl[7]  = '{4'h1, {16'h0, 16'h0, 16'h0, 16'hA020},       7'h00, 4'h1, 7'h10, 4, 16'hA020, 1'b0, 1'b0};
        tbl[8]  = '{4'h1, {16'h0, 16'h0, 16'h0, 16'h8001},       7'h00, 4'h1, 7'h08, 3, 16'h8001, 1'b0, 1'b0};
        tbl[9]  = '{4'h1, {16'h0, 16'h0, 16'h0, 16'h8002},       7'h08, 4'h1, 7'h08, 3, 16'h8002, 1'b0, 1'b0};
        tbl[10] = '{4'h1, {16'h0, 16'h0, 16'h0, 16'h8003},       7'h00, 4'h1, 7'h08, 3, 16'h8003, 1'b0, 1'b0};
        tbl[11] = '{4'h1, {16'h0, 16'h0, 16'h0, 16'h8004},       7'h00, 4'h1, 7'h08, 3, 16'h8004, 1'b0, 1'b0};
        tbl[12] = '{4'h1, {16'h0, 16'h0, 16'h0, 16'h8005},       7'h00, 4'h0, 7'h00, -1, 16'h0, 1'b0, 1'b0};
        tbl[13] = '{4'h1, {16'h0, 16'h0, 16'h0, 16'h8005},       7'h08, 4'h0, 7'h00, -1, 16'h0, 1'b0, 1'b0};
        tbl[14] = '{4'h1, {16'h0, 16'h0, 16'h0, 16'h8005},       7'h00, 4'h1, 7'h08, 3, 16'h8005, 1'b0, 1'b0};
        tbl[15] = '{4'h2, {16'h0, 16'h0, 16'h4000, 16'h0},       7'h00, 4'h2, 7'h00, -1, 16'h0, 1'b1, 1'b0};
        tbl[16] = '{4'h3, {16'h0, 16'h0, 16'hE002, 16'h0001},    7'h00, 4'h3, 7'h41, 0, 16'h0001, 1'b1, 1'b0};
        tbl[17] = '{4'h0, {16'h0, 16'h0, 16'h0, 16'h0},          7'h02, 4'h0, 7'h00, -1, 16'h0, 1'b1, 1'b1};

        // Reset state
        ARESET = 1'b1; req_valid = '0; req_data = '0; link_credit = '0;
        #12;
        chk("rst_link_valid", 64'(link_valid), 64'h0);
        chk("rst_link_data",  64'(link_data[63:0]), 64'h0);
        chk("rst_req_ready",  64'(req_ready), 64'h0);
        chk("rst_err_self",   64'(err_self), 64'h0);
        chk("rst_err_credit", 64'(err_credit), 64'h0);
        do_reset();

        // Directed table
        for (int i = 0; i < 18; i++) begin
            req_valid   = tbl[i].rv;
            req_data    = tbl[i].d;
            link_credit = tbl[i].lc;
            #1;
            chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].rdy));
            @(posedge ACLK);
            #1;
            chk($sformatf("tbl%0d_link_valid", i), 64'(link_valid), 64'(tbl[i].lv));
            if (tbl[i].cl >= 0)
                chk($sformatf("tbl%0d_link_data", i), 64'(link_data[tbl[i].cl*DW +: DW]), 64'(tbl[i].ld));
            chk($sformatf("tbl%0d_err_self", i), 64'(err_self), 64'(tbl[i].es));
            chk($sformatf("tbl%0d_err_credit", i), 64'(err_credit), 64'(tbl[i].ec));
        end
        chk("parallel_link6_data", 64'(link_data[6*DW +: DW]), 64'hE002);

        // Asynchronous reset in the middle of a burst on link 5
        req_valid = 4'h1; req_data = 64'hC055; link_credit = '0;
        @(posedge ACLK);
        #1;
        chk("burst_link5_valid", 64'(link_valid), 64'h20);
        #2;
        ARESET = 1'b1; req_valid = '0;
        #1;
        chk("async_rst_link_valid", 64'(link_valid), 64'h0);
        chk("async_rst_err_self",   64'(err_self), 64'h0);
        chk("async_rst_err_credit", 64'(err_credit), 64'h0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(posedge ACLK);
        #1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 4'h1; req_data = 64'hC0AA;
            #1;
            if (req_ready[0]) cnt++;
            @(posedge ACLK);
            #1;
        end
        chk("post_rst_credits", 64'(cnt), 64'd4);

        // Randomized traffic vs reference model
        do_reset();
        for (int l = 0; l < NL; l++) begin mcred[l] = CR; mstart[l] = 0; end
        for (int r = 0; r < NR; r++) pv[r] = 1'b0;
        mes = 1'b0; mec = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int r = 0; r < NR; r++) begin
                if (!pv[r] && $urandom_range(0, 3) != 0) begin
                    pv[r] = 1'b1;
                    pd[r] = 16'($urandom);
                end
                req_valid[r]           = pv[r];
                req_data[r*DW +: DW]   = pv[r] ? pd[r] : 16'h0;
            end
            for (int l = 0; l < NL; l++)
                link_credit[l] = (mcred[l] < CR) && ($urandom_range(0, 2) == 0);

            exp_rdy = '0;
            exp_lv  = '0;
            for (int r = 0; r < NR; r++)
                if (pv[r] && int'(pd[r][15:13]) == GID) exp_rdy[r] = 1'b1;
            for (int l = 0; l < NL; l++) begin
                win[l] = -1;
                if (mcred[l] > 0) begin
                    for (int k = 0; k < NR; k++) begin
                        int r;
                        r = (mstart[l] + k) % NR;
                        if (win[l] < 0 && pv[r] && int'(pd[r][15:13]) != GID &&
                            lk(int'(pd[r][15:13])) == l)
                            win[l] = r;
                    end
                end
                if (win[l] >= 0) begin
                    exp_rdy[win[l]] = 1'b1;
                    exp_lv[l]       = 1'b1;
                end
            end
            #1;
            chk($sformatf("rnd%0d_ready", cyc), 64'(req_ready), 64'(exp_rdy));
            @(posedge ACLK);
            #1;
            for (int r = 0; r < NR; r++)
                if (pv[r] && int'(pd[r][15:13]) == GID) mes = 1'b1;
            chk($sformatf("rnd%0d_link_valid", cyc), 64'(link_valid), 64'(exp_lv));
            for (int l = 0; l < NL; l++) begin
                if (win[l] >= 0)
                    chk($sformatf("rnd%0d_link%0d_data", cyc, l), 64'(link_data[l*DW +: DW]),
                        64'(pd[win[l]]));
            end
            chk($sformatf("rnd%0d_err_self", cyc), 64'(err_self), 64'(mes));
            chk($sformatf("rnd%0d_err_credit", cyc), 64'(err_credit), 64'(mec));

            for (int l = 0; l < NL; l++) begin
                mcred[l] = mcred[l] + int'(link_credit[l]) - ((win[l] >= 0) ? 1 : 0);
                if (win[l] >= 0) mstart[l] = (win[l] + 1) % NR;
            end
            for (int r = 0; r < NR; r++)
                if (exp_rdy[r]) pv[r] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/group_egress_arbiter.md
Name: group_egress_arbiter

Overview:
- Per-group scheduler that shares the group's 7 outbound global links (one to each other group) among NUM_REQ local router ports.
- Each requester presents single-flit packets whose destination-group field selects a link.
- Each link has its own round-robin arbiter and a credit counter, because the inter-group links carry only data+valid and have no ready.
- Sits between the local routers and the groupN_out_data/groupN_out_valid pins of a group.

Parameters:
- NUM_REQ, 4, number of local requesters.
- DATA_W, 16, flit width.
- GROUP_ID, 0, this group's id, 0..7.
- CREDITS, 4, receiver buffer depth per link; credit counter reset value.
- CNT_W, 3, credit counter width, ≥ clog2(CREDITS+1).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester flit valid.
- req_data  in  NUM_REQ*DATA_W  flits; bits [15:13] = destination group.
- req_ready  out  NUM_REQ  flit accepted this cycle.
- link_data  out  7*DATA_W  per-link flit, registered.
- link_valid  out  7  per-link valid, registered, one-cycle pulse per flit.
- link_credit  in  7  one-cycle credit return from the far group.
- err_self  out  1  sticky: flit addressed to GROUP_ID was dropped.
- err_credit  out  1  sticky: credit return while the counter was full.

Behaviour:
- Interface: one clock ACLK; ARESET is asynchronous, active-high.
- Reset values: req_ready=0, link_valid=0, link_data=0, credits=CREDITS, RR pointers=0, err_*=0. Reset mid-transfer discards in-flight flits and restores all credits; the bench also resets the far side.
- Link mapping: link = dest < GROUP_ID ? dest : dest-1.
- Self-addressed flit (dest==GROUP_ID): req_ready=1 the same cycle, flit dropped, err_self set.
- Per link L, each cycle:
  - Candidates are requesters with req_valid and mapped link L.
  - If credit[L]>0, grant one candidate by round-robin, starting at the requester after the last granted one.
  - req_ready of the winner goes high combinationally in the same cycle (valid/ready handshake, fires when both are high).
  - No grant when credit[L]==0; the link is STALLED until a credit arrives.
- Requesters hold req_valid and req_data stable until ready. A requester targets one link per cycle, so it gets at most one grant.
- Output: link_data/link_valid are registered, giving 1-cycle latency from handshake to link_valid. Back-to-back flits give link_valid high on consecutive cycles.
- Credits:
  - A grant decrements the counter; link_credit increments it.
  - Grant and credit in the same cycle: counter unchanged.
  - Credit while at CREDITS: counter held, err_credit set.
- RR pointer advances only on a grant. Pointers are independent per link. Starvation-free: each candidate is served within NUM_REQ grants.
- Per-link state is ACTIVE (credit>0) or STALLED (credit==0); both are derived from the counter.
- Sticky errors clear only on reset.

Optional Feature:
- ARB_STATS_EN defined: adds output stat_stall, 7*16 bits. Per-link saturating counters increment on each cycle with candidates present but credit==0.
- ARB_STATS_EN undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared noc_pkg holds:
  - DATA_W, GRP_W=3, NUM_GROUPS=8, NUM_LINKS=7.
  - Destination field position constants.
  - Function dest_to_link(dest, group_id).
  - Credit defaults.
- One natural sub-module, rr_arbiter: NUM_REQ request vector in, one-hot grant out, pointer update on enable. Instantiated 7 times.

Test Plan:
- GROUP_ID=2, requester 0 sends 0x8ABC (dest 4) → 1 cycle later link 3 shows link_valid=1 and link_data=0x8ABC; link 3 credit drops 4→3.
- Requesters 0..3 all target dest 5, no credit return → exactly 4 flits go out in order 0,1,2,3 and all req_ready then stay 0. Pulse link_credit[4] once → requester 0's next flit is granted the following cycle.
- Simultaneous grant and link_credit on the same link at credit=2 → credit stays 2; no flit lost or duplicated.
- Flit with dest==GROUP_ID → req_ready=1, no link_valid on any link, err_self=1.
- link_credit pulse at credit=4 → credit remains 4 and err_credit=1. ARESET asserted mid-burst → all link_valid=0 asynchronously, credits=4, errors cleared.
- Requesters 0 and 1 target dests 0 and 7 concurrently (GROUP_ID=2, links 0 and 6) → both granted in the same cycle, with parallel link_valid.
